instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 19 +
 rtl/instr_loader_pack.sv | 53 +++++
 rtl/instr_loader.sv | 109 ++++++++++
 tb/tb_instr_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: default store depth,
// bus widths, FSM state encoding and the NOP word returned for
// unloaded or masked reads.
package instr_loader_pkg;

  localparam int unsigned DEPTH_LOG2_DEF = 6;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned IDX_W          = 2;

  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

endpackage : instr_loader_pkg

// File: rtl/instr_loader_pack.sv
// Little-endian byte packer for the instruction loader.
// Ports:
//   clock, reset   : clock and async active-high reset
//   byte_i         : incoming program byte
//   accept_i       : byte handshake completes this cycle
//   last_i         : accepted byte is the final program byte
//   wdata_c_o      : word assembled so far including byte_i (unfilled bytes zero)
//   wr_c_o         : word-complete strobe (fourth byte or last byte accepted)
module instr_loader_pack
  import instr_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              accept_i,
  input  logic              last_i,
  output logic [WORD_W-1:0] wdata_c_o,
  output logic              wr_c_o
);

  logic [IDX_W-1:0]  idx_q,  idx_d;
  logic [WORD_W-1:0] part_q, part_d;

  // Byte index and partial word; upper bytes stay zero because the
  // partial word is cleared whenever a word is emitted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      part_q <= '0;
    end else begin
      idx_q  <= idx_d;
      part_q <= part_d;
    end
  end

  // Merge the current byte into its lane and decide whether the word is done.
  always_comb begin
    wdata_c_o = part_q | (WORD_W'(byte_i) << {idx_q, 3'b000});
    wr_c_o    = accept_i && ((idx_q == IDX_W'(3)) || last_i);
    idx_d     = idx_q;
    part_d    = part_q;
    if (accept_i) begin
      if (wr_c_o) begin
        idx_d  = '0;
        part_d = '0;
      end else begin
        idx_d  = idx_q + IDX_W'(1);
        part_d = wdata_c_o;
      end
    end
  end

endmodule : instr_loader_pack

// File: rtl/instr_loader.sv
// Instruction loader: receives a program as a byte stream, packs it into
// 32-bit words in a local store, then serves instruction fetches.
// Ports:
//   clock, reset : clock and async active-high reset
//   in_data      : program byte from host      in_valid : byte valid
//   in_last      : final program byte          in_ready : accepting bytes (LOAD)
//   raddr        : fetch word address          instr    : fetched word (combinational)
//   run          : program loaded              err      : program overflowed store
//   words        : number of words written
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BYTE_W-1:0]     in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic [31:0]           raddr,
  output logic [WORD_W-1:0]     instr,
  output logic                  run,
  output logic                  err,
  output logic [DEPTH_LOG2:0]   words
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic [WORD_W-1:0]  store [DEPTH];

  logic               accept;
  logic [WORD_W-1:0]  wdata_c;
  logic               wr_c;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic               unused_raddr;

  assign accept = in_valid && (state_q == ST_LOAD);

  instr_loader_pack u_pack (
    .clock     (clock),
    .reset     (reset),
    .byte_i    (in_data),
    .accept_i  (accept),
    .last_i    (in_last),
    .wdata_c_o (wdata_c),
    .wr_c_o    (wr_c)
  );

  // State and word count registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
    end
  end

  // Next state: last byte wins over a full store, so a program that
  // exactly fills the store still runs.
  always_comb begin
    state_d = state_q;
    words_d = words_q;
    case (state_q)
      ST_LOAD: begin
        if (wr_c) begin
          words_d = words_q + CNT_W'(1);
        end
        if (accept && in_last) begin
          state_d = ST_RUN;
        end else if (wr_c && (words_q == CNT_W'(DEPTH - 1))) begin
          state_d = ST_ERR;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_LOAD;
    endcase
  end

  // Store is not reset; reads beyond words are masked instead.
  always_ff @(posedge clock) begin
    if (wr_c) begin
      store[words_q[DEPTH_LOG2-1:0]] <= wdata_c;
    end
  end

  // Fetch address wraps modulo the store depth.
  assign rd_idx       = raddr[DEPTH_LOG2-1:0];
  assign unused_raddr = ^raddr[31:DEPTH_LOG2];

  always_comb begin
    instr = NOP_WORD;
    if ((state_q == ST_RUN) && ({1'b0, rd_idx} < words_q)) begin
      instr = store[rd_idx];
    end
  end

  assign in_ready = (state_q == ST_LOAD);
  assign run      = (state_q == ST_RUN);
  assign err      = (state_q == ST_ERR);
  assign words    = words_q;

endmodule : instr_loader

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] raddr = '0;
  logic [31:0] instr;
  logic        run;
  logic        err;
  logic [6:0]  words;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } rd_vec_t;

  instr_loader #(.DEPTH_LOG2(6)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .raddr    (raddr),
    .instr    (instr),
    .run      (run),
    .err      (err),
    .words    (words)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // One byte with a handshake on the next rising edge; returns #1 after it.
  task automatic send(input logic [7:0] b, input logic last);
    in_data  = b;
    in_valid = 1'b1;
    in_last  = last;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_words_async", 32'(words), 32'd0);
    check("rst_run_async", 32'(run), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    check(name, instr, exp);
  endtask

  rd_vec_t     t1 [6];
  rd_vec_t     t2 [5];
  logic [7:0]  ref_bytes [11];
  logic [31:0] ref_words [3];
  logic [31:0] snap [2];
  logic [6:0]  words_snap;

  initial begin
    t1[0] = '{32'd0,  32'h0403_0201};
    t1[1] = '{32'd1,  32'h0807_0605};
    t1[2] = '{32'd2,  32'h0000_0000};
    t1[3] = '{32'd63, 32'h0000_0000};
    t1[4] = '{32'd64, 32'h0403_0201};
    t1[5] = '{32'd65, 32'h0807_0605};

    t2[0] = '{32'd0,  32'hDDCC_BBAA};
    t2[1] = '{32'd1,  32'h0000_00EE};
    t2[2] = '{32'd2,  32'h0000_0000};
    t2[3] = '{32'd66, 32'h0000_0000};
    t2[4] = '{32'd65, 32'h0000_00EE};

    // Reset state
    #1;
    do_reset();
    raddr = '0;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_run", 32'(run), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_words", 32'(words), 32'd0);
    check("reset_instr", instr, 32'h0);

    // Eight bytes, last on 0x08
    for (int i = 1; i <= 7; i++) send(8'(i), 1'b0);
    check("t1_run_before_last", 32'(run), 32'd0);
    check("t1_words_before_last", 32'(words), 32'd1);
    check("t1_instr_in_load", instr, 32'h0);
    send(8'h08, 1'b1);
    check("t1_run", 32'(run), 32'd1);
    check("t1_words", 32'(words), 32'd2);
    check("t1_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 6; i++) read_chk($sformatf("t1_rd%0d", i), t1[i].addr, t1[i].exp);

    // Five bytes: partial final word is zero-filled
    do_reset();
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0);
    send(8'hDD, 1'b0); send(8'hEE, 1'b1);
    check("t2_words", 32'(words), 32'd2);
    check("t2_run", 32'(run), 32'd1);
    for (int i = 0; i < 5; i++) read_chk($sformatf("t2_rd%0d", i), t2[i].addr, t2[i].exp);

    // 256 bytes without last overflow the store
    do_reset();
    for (int i = 0; i < 255; i++) send(8'(i), 1'b0);
    check("t3_err_before", 32'(err), 32'd0);
    check("t3_ready_before", 32'(in_ready), 32'd1);
    check("t3_words_before", 32'(words), 32'd63);
    send(8'hFF, 1'b0);
    check("t3_err", 32'(err), 32'd1);
    check("t3_in_ready", 32'(in_ready), 32'd0);
    check("t3_run", 32'(run), 32'd0);
    check("t3_words", 32'(words), 32'd64);
    read_chk("t3_instr", 32'd0, 32'h0);
    send(8'h12, 1'b1);
    check("t3_err_sticky", 32'(err), 32'd1);
    check("t3_words_sticky", 32'(words), 32'd64);

    // 256 bytes with last on the final byte exactly fills the store and runs
    do_reset();
    for (int i = 0; i < 255; i++) send(8'(i), 1'b0);
    send(8'hFF, 1'b1);
    check("t3b_run", 32'(run), 32'd1);
    check("t3b_err", 32'(err), 32'd0);
    check("t3b_words", 32'(words), 32'd64);
    read_chk("t3b_rd0", 32'd0, 32'h0302_0100);
    read_chk("t3b_rd63", 32'd63, 32'hFFFE_FDFC);

    // Random in_valid gaps: only handshaken bytes are packed
    do_reset();
    for (int i = 0; i < 11; i++) ref_bytes[i] = 8'($urandom_range(0, 255));
    for (int w = 0; w < 3; w++) ref_words[w] = '0;
    for (int i = 0; i < 11; i++) ref_words[i / 4] |= 32'(ref_bytes[i]) << (8 * (i % 4));
    for (int i = 0; i < 11; i++) begin
      int gaps;
      gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        in_data = 8'($urandom_range(0, 255));
        idle(1);
      end
      send(ref_bytes[i], (i == 10));
    end
    check("t4_words", 32'(words), 32'd3);
    check("t4_run", 32'(run), 32'd1);
    for (int w = 0; w < 3; w++) read_chk($sformatf("t4_rd%0d", w), 32'(w), ref_words[w]);

    // Reset mid-load discards partial program
    do_reset();
    for (int i = 0; i < 6; i++) send(8'hF0 + 8'(i), 1'b0);
    do_reset();
    check("t5_words_after_rst", 32'(words), 32'd0);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
    check("t5_words", 32'(words), 32'd1);
    read_chk("t5_rd0", 32'd0, 32'h4433_2211);
    read_chk("t5_rd1", 32'd1, 32'h0);

    // In RUN, in_valid is ignored
    words_snap = words;
    read_chk("t6_pre_rd0", 32'd0, 32'h4433_2211);
    snap[0] = 32'h4433_2211;
    snap[1] = 32'h0;
    for (int c = 0; c < 10; c++) begin
      in_data  = 8'hC0 + 8'(c);
      in_valid = 1'b1;
      in_last  = c[0];
      #1;
      check($sformatf("t6_in_ready%0d", c), 32'(in_ready), 32'd0);
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t6_words", 32'(words), 32'(words_snap));
    check("t6_run", 32'(run), 32'd1);
    for (int w = 0; w < 2; w++) read_chk($sformatf("t6_rd%0d", w), 32'(w), snap[w]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_instr_loader
